// File: rtl/blk_mem_pkg.sv
// Shared types and constants for the single-port block memory.
package blk_mem_pkg;

  // Read-during-write behaviour of the data output
  typedef enum logic [1:0] {
    WRITE_FIRST,
    READ_FIRST,
    NO_CHANGE
  } rd_mode_t;

  // Power-up image used when no hex file is supplied:
  // Z80 program "LD A,9Ah ; LD (HL),A"
  localparam logic [7:0] INIT_WORD0 = 8'h3E;
  localparam logic [7:0] INIT_WORD1 = 8'h9A;
  localparam logic [7:0] INIT_WORD2 = 8'h77;

endpackage

// File: rtl/blk_mem_out_reg.sv
// Optional output pipeline stage for the block memory read data.
module blk_mem_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Capture read data only when a read was launched the cycle before
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/blk_mem_gen.sv
// Single-port synchronous block memory with selectable read-during-write
// policy, optional output register and power-up image.
module blk_mem_gen
  import blk_mem_pkg::*;
#(
  parameter int       ADDR_W    = 17,
  parameter int       DATA_W    = 8,
  parameter int       DEPTH     = 131072,
  parameter rd_mode_t RD_MODE   = WRITE_FIRST,
  parameter int       OUT_REG   = 0,
  parameter string    INIT_FILE = ""
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t mem_t [DEPTH];

  // Builds the power-up contents: the built-in three-word program when no
  // image name is given; everything not covered stays zero.
  function automatic mem_t load_image();
    mem_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = '0;
    end
    if (INIT_FILE == "") begin
      if (DEPTH > 0) img[0] = word_t'(INIT_WORD0);
      if (DEPTH > 1) img[1] = word_t'(INIT_WORD1);
      if (DEPTH > 2) img[2] = word_t'(INIT_WORD2);
    end
    return img;
  endfunction

  mem_t             mem = load_image();
  logic             in_range;
  logic [IDX_W-1:0] idx;
  word_t            rd_q;

  // Addresses past the implemented depth never alias onto real words
  assign in_range = ({1'b0, addra} < DEPTH_L);
  assign idx      = addra[IDX_W-1:0];

  // Array write port, kept free of reset so it maps onto block RAM
  always_ff @(posedge clka) begin
    if (rst_n && ena && wea && in_range) begin
      mem[idx] <= dina;
    end
  end

  // Synchronous read register with the read-during-write policy applied
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (ena) begin
      if (!wea) begin
        rd_q <= in_range ? mem[idx] : '0;
      end else begin
        case (RD_MODE)
          WRITE_FIRST: rd_q <= in_range ? dina : '0;
          READ_FIRST:  rd_q <= in_range ? mem[idx] : '0;
          default:     rd_q <= rd_q;
        endcase
      end
    end
  end

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic ena_q;

      // Remember whether the read register was loaded last cycle
      always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
          ena_q <= 1'b0;
        end else begin
          ena_q <= ena;
        end
      end

      blk_mem_out_reg #(
        .DATA_W(DATA_W)
      ) u_out_reg (
        .clka (clka),
        .rst_n(rst_n),
        .en   (ena_q),
        .d    (rd_q),
        .q    (douta)
      );
    end else begin : g_no_out_reg
      assign douta = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_blk_mem_gen.sv
// Directed bench: five memory variants share one stimulus stream and each
// output is compared against hand-computed values.
module tb_blk_mem_gen;
  import blk_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        wea;
  logic [16:0] addra;
  logic [7:0]  dina;
  logic [7:0]  dout_wf;
  logic [7:0]  dout_rf;
  logic [7:0]  dout_nc;
  logic [7:0]  dout_or;
  logic [7:0]  dout_sm;

  int checks   = 0;
  int failures = 0;

  blk_mem_gen #(.RD_MODE(WRITE_FIRST)) dut_wf (
    .clka(clk), .rst_n(rst_n), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(dout_wf)
  );

  blk_mem_gen #(.RD_MODE(READ_FIRST)) dut_rf (
    .clka(clk), .rst_n(rst_n), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(dout_rf)
  );

  blk_mem_gen #(.RD_MODE(NO_CHANGE)) dut_nc (
    .clka(clk), .rst_n(rst_n), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(dout_nc)
  );

  blk_mem_gen #(.RD_MODE(WRITE_FIRST), .OUT_REG(1)) dut_or (
    .clka(clk), .rst_n(rst_n), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(dout_or)
  );

  blk_mem_gen #(.DEPTH(1024)) dut_sm (
    .clka(clk), .rst_n(rst_n), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(dout_sm)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one operation at the falling edge, return 1 unit after the
  // rising edge that consumes it
  task automatic applyStimulus(input logic e, input logic w,
                               input logic [16:0] a, input logic [7:0] d);
    @(negedge clk);
    ena   = e;
    wea   = w;
    addra = a;
    dina  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Safety net in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;

    // Reset held two cycles; a read and a write attempt are ignored
    applyStimulus(1'b1, 1'b0, 17'h0, 8'h00);
    checkOutput("rst_c1_wf", dout_wf, 8'h00);
    checkOutput("rst_c1_or", dout_or, 8'h00);
    applyStimulus(1'b1, 1'b1, 17'h0, 8'hFF);
    checkOutput("rst_c2_wf", dout_wf, 8'h00);
    checkOutput("rst_c2_sm", dout_sm, 8'h00);
    #2 rst_n = 1'b1;

    // Initial image reads back; the write during reset did not land
    applyStimulus(1'b1, 1'b0, 17'h0, 8'h00);
    checkOutput("init0_wf", dout_wf, 8'h3E);
    checkOutput("init0_rf", dout_rf, 8'h3E);
    checkOutput("init0_or_lat", dout_or, 8'h00);
    applyStimulus(1'b1, 1'b0, 17'h1, 8'h00);
    checkOutput("init1_wf", dout_wf, 8'h9A);
    checkOutput("init1_sm", dout_sm, 8'h9A);
    checkOutput("or_init0", dout_or, 8'h3E);
    applyStimulus(1'b1, 1'b0, 17'h2, 8'h00);
    checkOutput("init2_wf", dout_wf, 8'h77);
    checkOutput("init2_nc", dout_nc, 8'h77);
    checkOutput("or_init1", dout_or, 8'h9A);

    // Read addr 1, then idle with wea pulsed and address/data moving
    applyStimulus(1'b1, 1'b0, 17'h1, 8'h00);
    checkOutput("rd1_wf", dout_wf, 8'h9A);
    checkOutput("or_init2", dout_or, 8'h77);
    applyStimulus(1'b0, 1'b1, 17'h1, 8'hC3);
    checkOutput("ena0_wr_wf", dout_wf, 8'h9A);
    checkOutput("ena0_wr_or", dout_or, 8'h9A);
    applyStimulus(1'b0, 1'b0, 17'h5, 8'h11);
    checkOutput("ena0_hold_wf", dout_wf, 8'h9A);
    checkOutput("ena0_hold_or", dout_or, 8'h9A);
    applyStimulus(1'b1, 1'b0, 17'h1, 8'h00);
    checkOutput("mem1_kept_wf", dout_wf, 8'h9A);
    checkOutput("mem1_kept_rf", dout_rf, 8'h9A);

    // Write 55 over 3E at address 0 under each read-during-write policy
    applyStimulus(1'b1, 1'b1, 17'h0, 8'h55);
    checkOutput("wr0_write_first", dout_wf, 8'h55);
    checkOutput("wr0_read_first", dout_rf, 8'h3E);
    checkOutput("wr0_no_change", dout_nc, 8'h9A);
    checkOutput("wr0_sm", dout_sm, 8'h55);
    applyStimulus(1'b1, 1'b0, 17'h0, 8'h00);
    checkOutput("rd0_wf", dout_wf, 8'h55);
    checkOutput("rd0_rf", dout_rf, 8'h55);
    checkOutput("rd0_nc", dout_nc, 8'h55);
    checkOutput("rd0_or_pipe", dout_or, 8'h55);

    // Top of the 17-bit address space
    applyStimulus(1'b1, 1'b1, 17'h1FFFF, 8'hA5);
    checkOutput("wrtop_wf", dout_wf, 8'hA5);
    checkOutput("wrtop_rf", dout_rf, 8'h00);
    checkOutput("wrtop_nc", dout_nc, 8'h55);
    applyStimulus(1'b1, 1'b0, 17'h1FFFF, 8'h00);
    checkOutput("rdtop_wf", dout_wf, 8'hA5);
    checkOutput("rdtop_nc", dout_nc, 8'hA5);
    checkOutput("rdtop_sm", dout_sm, 8'h00);
    checkOutput("rdtop_or_pipe", dout_or, 8'hA5);
    applyStimulus(1'b1, 1'b0, 17'h1FFFE, 8'h00);
    checkOutput("rdtop1_wf", dout_wf, 8'h00);
    checkOutput("rdtop1_or", dout_or, 8'hA5);

    // Small instance: address 1024 is outside its depth
    applyStimulus(1'b1, 1'b1, 17'd1024, 8'hBB);
    applyStimulus(1'b1, 1'b0, 17'd1024, 8'h00);
    checkOutput("oob_rd_sm", dout_sm, 8'h00);
    checkOutput("oob_rd_wf", dout_wf, 8'hBB);
    applyStimulus(1'b1, 1'b0, 17'h0, 8'h00);
    checkOutput("oob_no_alias_sm", dout_sm, 8'h55);

    // Reset in the middle of the output pipeline
    applyStimulus(1'b1, 1'b0, 17'h2, 8'h00);
    checkOutput("pre_rst_wf", dout_wf, 8'h77);
    checkOutput("pre_rst_or", dout_or, 8'h55);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_or", dout_or, 8'h00);
    checkOutput("async_rst_wf", dout_wf, 8'h00);
    applyStimulus(1'b0, 1'b0, 17'h0, 8'h00);
    #2 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 17'h0, 8'h00);
    checkOutput("post_rst_or", dout_or, 8'h00);
    checkOutput("post_rst_wf", dout_wf, 8'h00);
    applyStimulus(1'b1, 1'b0, 17'h2, 8'h00);
    checkOutput("post_rst_rd_wf", dout_wf, 8'h77);
    checkOutput("post_rst_rd_or_lat", dout_or, 8'h00);
    applyStimulus(1'b0, 1'b0, 17'h0, 8'h00);
    checkOutput("post_rst_rd_or", dout_or, 8'h77);
    checkOutput("post_rst_hold_wf", dout_wf, 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blk_mem_gen.md
BLK_MEM_GEN -- requirements
Module: blk_mem_gen

Interface
REQ-001 Parameter ADDR_W, default 17, address width in bits.
REQ-002 Parameter DATA_W, default 8, data width in bits.
REQ-003 Parameter DEPTH, default 131072, number of implemented words; must be no greater than 2**ADDR_W.
REQ-004 Parameter RD_MODE, default WRITE_FIRST, read-during-write policy; one of WRITE_FIRST, READ_FIRST, NO_CHANGE.
REQ-005 Parameter OUT_REG, default 0, adds one output pipeline stage when set to 1.
REQ-006 Parameter INIT_FILE, default empty string, hex image loaded at elaboration.
REQ-007 clka  input  1  sole clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 ena  input  1  port enable; no read or write happens when low.
REQ-010 wea  input  1  write enable, qualified by ena.
REQ-011 addra  input  ADDR_W  word address.
REQ-012 dina  input  DATA_W  write data.
REQ-013 douta  output  DATA_W  read data.

Function
REQ-014 Storage SHALL be DEPTH x DATA_W, single port, synchronous.
REQ-015 A write SHALL occur when ena=1 and wea=1 at a clka edge: mem[addra] <= dina.
REQ-016 A read SHALL occur when ena=1 and wea=0; douta SHALL show mem[addra] one cycle after the edge when OUT_REG=0, and two cycles after when OUT_REG=1.
REQ-017 When ena=0, douta SHALL hold its previous value and memory SHALL be unchanged.
REQ-018 Write with WRITE_FIRST: douta SHALL show dina on the next cycle.
REQ-019 Write with READ_FIRST: douta SHALL show the old mem[addra] on the next cycle.
REQ-020 Write with NO_CHANGE: douta SHALL hold its value.
REQ-021 Any addra >= DEPTH SHALL read as 0 and SHALL ignore writes, with no wrap-around.
REQ-022 With INIT_FILE empty, initial contents SHALL be mem[0]=8'h3E, mem[1]=8'h9A, mem[2]=8'h77, all other words 0 (Z80 program LD A,9Ah; LD (HL),A).
REQ-023 With INIT_FILE non-empty, contents SHALL be loaded from the file; words the file does not cover SHALL be 0.
REQ-024 Back-to-back operations at different addresses SHALL sustain one operation per cycle with no stall.
REQ-025 When OUT_REG=1, the pipeline register SHALL advance only when ena was high in the previous cycle, so latency stays fixed.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear douta and the pipeline register to 0.
REQ-027 Reset SHALL NOT alter memory contents.
REQ-028 Operations SHALL be ignored while rst_n=0.
REQ-029 The first operation SHALL take effect on the first clka edge after rst_n rises.
REQ-030 Reset asserted during a read SHALL discard that read; douta SHALL stay 0 until a new read completes.

Structure
REQ-031 Package blk_mem_pkg SHALL hold the rd_mode_t enum (WRITE_FIRST, READ_FIRST, NO_CHANGE) and the default init constants 3E/9A/77.
REQ-032 The array SHALL use synchronous read only so it infers block RAM; it SHALL have no reset on the array.
REQ-033 The optional output stage SHALL be one sub-module, blk_mem_out_reg, parameterised by DATA_W and holding the async reset.

Verification
REQ-034 Hold rst_n=0 for 2 cycles, then release and read addresses 0, 1, 2 with ena=1, wea=0 -> douta = 3E, 9A, 77 one cycle after each, and 0 while reset was held.
REQ-035 Write 8'hA5 to address 17'h1FFFF, then read it back -> 8'hA5; address 17'h1FFFE reads 0.
REQ-036 Write 8'h55 to address 0, which holds 3E, under each RD_MODE -> next-cycle douta is 55 for WRITE_FIRST, 3E for READ_FIRST, and the prior value for NO_CHANGE; a later read returns 55 in all modes.
REQ-037 Read address 1, drop ena, change addra and dina, and pulse wea -> douta stays 9A and memory is unchanged.
REQ-038 Set OUT_REG=1 and read address 2 -> 77 appears exactly two cycles later; asserting rst_n=0 mid-pipeline clears douta to 0 immediately.
REQ-039 Set DEPTH=1024, write address 1024, then read it -> douta = 0 and address 0 is not corrupted.
